// File: rtl/lcd_update_arbiter_if.sv
// Requester and LCD-side signal bundle for lcd_update_arbiter.
// The slave modport is the arbiter; the master modport is the client/LCD side.
interface lcd_update_arbiter_if #(
  parameter int NUM_REQ     = 4,
  parameter int LINE_LENGTH = 16
);
  localparam int LW = 8 * LINE_LENGTH;

  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ*LW-1:0] req_line1;
  logic [NUM_REQ*LW-1:0] req_line2;
  logic [NUM_REQ-1:0]    grant;
  logic [NUM_REQ-1:0]    ack;
  logic                  timeout;
  logic                  busy;
  logic                  lcd_send;
  logic [LW-1:0]         lcd_line1;
  logic [LW-1:0]         lcd_line2;
  logic                  lcd_done;

  modport master (
    output req, req_line1, req_line2, lcd_done,
    input  grant, ack, timeout, busy, lcd_send, lcd_line1, lcd_line2
  );

  modport slave (
    input  req, req_line1, req_line2, lcd_done,
    output grant, ack, timeout, busy, lcd_send, lcd_line1, lcd_line2
  );
endinterface

// File: rtl/lcd_update_arbiter.sv
// Round-robin arbiter sharing the two-line LCD text path between requesters.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | no transfer; arbitrate among set req bits starting after ptr
// SEND   | winner text latched; lcd_send strobe registered this cycle
// WAIT   | waiting for lcd_done rising edge or timeout down-counter at 0
// GAP    | enforcing the minimum idle gap before the next arbitration
module lcd_update_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int LINE_LENGTH = 16,
  parameter int MIN_GAP     = 1000,
  parameter int TIMEOUT     = 2_000_000
) (
  input logic            CLK,
  input logic            RESET,
  lcd_update_arbiter_if.slave bus
);
  localparam int LW    = 8 * LINE_LENGTH;
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

  localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'(TIMEOUT);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((MIN_GAP > 0) ? MIN_GAP - 1 : 0);
  localparam logic [LW-1:0]    SPACES   = {LINE_LENGTH{8'h20}};
  localparam logic [PTR_W-1:0] PTR_INIT = PTR_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               timeout_q, timeout_d;
  logic               busy_q, busy_d;
  logic               send_q, send_d;
  logic [LW-1:0]      line1_q, line1_d;
  logic [LW-1:0]      line2_q, line2_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               done_q;

  logic               found;
  logic [PTR_W-1:0]   cand;
  logic [PTR_W-1:0]   win;
  logic [NUM_REQ-1:0] win_oh;
  logic [LW-1:0]      sel_line1;
  logic [LW-1:0]      sel_line2;
  logic               done_rise;

  assign done_rise = bus.lcd_done & ~done_q;

  // Round-robin search upward from ptr+1 and select the winner's text.
  always_comb begin
    found     = 1'b0;
    cand      = '0;
    win       = ptr_q;
    win_oh    = '0;
    sel_line1 = '0;
    sel_line2 = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    win_oh[win] = 1'b1;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win == PTR_W'(k)) begin
        sel_line1 = bus.req_line1[k*LW +: LW];
        sel_line2 = bus.req_line2[k*LW +: LW];
      end
    end
  end

  // Next-state and registered-output decode; every output is a flop.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    ack_d     = '0;
    timeout_d = 1'b0;
    send_d    = 1'b0;
    line1_d   = line1_q;
    line2_d   = line2_q;
    to_cnt_d  = to_cnt_q;
    gap_cnt_d = gap_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          line1_d = sel_line1;
          line2_d = sel_line2;
          grant_d = win_oh;
          ptr_d   = win;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        send_d   = 1'b1;
        to_cnt_d = TO_LOAD;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        // A done edge in the same cycle as terminal count still completes.
        if (done_rise || to_cnt_q == '0) begin
          if (done_rise) ack_d = grant_q;
          else           timeout_d = 1'b1;
          grant_d = '0;
          if (MIN_GAP == 0) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_GAP;
            gap_cnt_d = GAP_LOAD;
          end
        end else begin
          to_cnt_d = to_cnt_q - TO_W'(1);
        end
      end
      S_GAP: begin
        if (gap_cnt_q == '0) state_d = S_IDLE;
        else                 gap_cnt_d = gap_cnt_q - GAP_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; done_q tracks lcd_done in every state.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      ptr_q     <= PTR_INIT;
      grant_q   <= '0;
      ack_q     <= '0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
      send_q    <= 1'b0;
      line1_q   <= SPACES;
      line2_q   <= SPACES;
      to_cnt_q  <= '0;
      gap_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      ack_q     <= ack_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
      send_q    <= send_d;
      line1_q   <= line1_d;
      line2_q   <= line2_d;
      to_cnt_q  <= to_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      done_q    <= bus.lcd_done;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.ack       = ack_q;
  assign bus.timeout   = timeout_q;
  assign bus.busy      = busy_q;
  assign bus.lcd_send  = send_q;
  assign bus.lcd_line1 = line1_q;
  assign bus.lcd_line2 = line2_q;
endmodule

// File: tb/tb_lcd_update_arbiter.sv
// Randomized bench for lcd_update_arbiter against a transaction-level model.
module tb_lcd_update_arbiter;
  localparam int NR = 4;
  localparam int LL = 16;
  localparam int LW = 8 * LL;
  localparam int MG = 4;
  localparam int TO = 100;
  localparam logic [LW-1:0] SPACES = {LL{8'h20}};

  logic clk;
  logic rst;
  logic [LW-1:0] line1_v [NR];
  logic [LW-1:0] line2_v [NR];
  int n_vec;
  int n_err;
  int mdl_ptr;
  bit prev_keep;

  lcd_update_arbiter_if #(.NUM_REQ(NR), .LINE_LENGTH(LL)) bus_if ();

  lcd_update_arbiter #(
    .NUM_REQ(NR), .LINE_LENGTH(LL), .MIN_GAP(MG), .TIMEOUT(TO)
  ) dut (
    .CLK(clk),
    .RESET(rst),
    .bus(bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    bus_if.req_line1 = '0;
    bus_if.req_line2 = '0;
    for (int i = 0; i < NR; i++) begin
      bus_if.req_line1[i*LW +: LW] = line1_v[i];
      bus_if.req_line2[i*LW +: LW] = line2_v[i];
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Round-robin rule: first set request searching upward from last winner + 1.
  function automatic int pick(input logic [NR-1:0] r, input int p);
    for (int k = 1; k <= NR; k++)
      if (r[(p + k) % NR]) return (p + k) % NR;
    return -1;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_grant"}, 128'(bus_if.grant), 128'(0));
    chk({tag, "_ack"}, 128'(bus_if.ack), 128'(0));
    chk({tag, "_timeout"}, 128'(bus_if.timeout), 128'(0));
    chk({tag, "_busy"}, 128'(bus_if.busy), 128'(0));
    chk({tag, "_send"}, 128'(bus_if.lcd_send), 128'(0));
    chk({tag, "_line1"}, 128'(bus_if.lcd_line1), 128'(SPACES));
    chk({tag, "_line2"}, 128'(bus_if.lcd_line2), 128'(SPACES));
  endtask

  // One complete transfer; called at a negedge with the DUT idle and req set.
  // lat < 0: LCD never signals done. stuck: lcd_done is already high on entry.
  task automatic do_transfer(input int lat, input bit stuck, input bit keep_high);
    int w, evt_j, exp_j, cnt, bad_grant, sends;
    bit exp_to;
    logic [NR-1:0] eg;
    logic [LW-1:0] e1, e2;
    w = pick(bus_if.req, mdl_ptr);
    if (w < 0) begin
      $display("FAIL bench_setup: no request pending");
      n_err++;
      return;
    end
    eg = '0;
    eg[w] = 1'b1;
    e1 = line1_v[w];
    e2 = line2_v[w];
    @(negedge clk);
    chk("grant", 128'(bus_if.grant), 128'(eg));
    chk("busy_on", 128'(bus_if.busy), 128'(1));
    chk("line1", 128'(bus_if.lcd_line1), 128'(e1));
    chk("line2", 128'(bus_if.lcd_line2), 128'(e2));
    chk("send_early", 128'(bus_if.lcd_send), 128'(0));
    for (int i = 0; i < NR; i++) begin
      line1_v[i] = rand_line();
      line2_v[i] = rand_line();
    end
    bus_if.req = NR'($urandom_range(0, 15));
    @(negedge clk);
    chk("send", 128'(bus_if.lcd_send), 128'(1));
    chk("line1_hold", 128'(bus_if.lcd_line1), 128'(e1));
    chk("line2_hold", 128'(bus_if.lcd_line2), 128'(e2));
    exp_j = (lat >= 0) ? (stuck ? lat + 4 : lat + 1) : 100000;
    exp_to = (exp_j > TO + 1);
    if (exp_to) exp_j = TO + 1;
    evt_j = -1;
    bad_grant = 0;
    sends = 0;
    for (int j = 0; j <= TO + 20 && evt_j < 0; j++) begin
      if (j > 0) begin
        @(negedge clk);
        if (bus_if.ack != '0 || bus_if.timeout) begin
          evt_j = j;
        end else begin
          if (bus_if.grant != eg) bad_grant++;
          if (bus_if.lcd_send) sends++;
        end
      end
      if (evt_j < 0 && lat >= 0) begin
        if (stuck) begin
          if (j == lat) bus_if.lcd_done = 1'b0;
          if (j == lat + 3) bus_if.lcd_done = 1'b1;
        end else if (j == lat) begin
          bus_if.lcd_done = 1'b1;
        end
      end
    end
    chk("evt_cycle", 128'(evt_j), 128'(exp_j));
    chk("ack", 128'(bus_if.ack), exp_to ? 128'(0) : 128'(eg));
    chk("timeout", 128'(bus_if.timeout), 128'(exp_to));
    chk("grant_clr", 128'(bus_if.grant), 128'(0));
    chk("grant_held", 128'(bad_grant), 128'(0));
    chk("one_send", 128'(sends), 128'(0));
    if (!keep_high) bus_if.lcd_done = 1'b0;
    prev_keep = keep_high;
    mdl_ptr = w;
    cnt = 0;
    while (bus_if.busy && cnt < 20) begin
      cnt++;
      bus_if.req = NR'($urandom_range(0, 15));
      @(negedge clk);
      if (cnt == 1) begin
        chk("ack_pulse", 128'(bus_if.ack), 128'(0));
        chk("to_pulse", 128'(bus_if.timeout), 128'(0));
      end
    end
    chk("gap_len", 128'(cnt), 128'(MG));
    chk("idle_grant", 128'(bus_if.grant), 128'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    bit keep;
    n_vec = 0;
    n_err = 0;
    prev_keep = 1'b0;
    rst = 1'b1;
    bus_if.req = '0;
    bus_if.lcd_done = 1'b0;
    for (int i = 0; i < NR; i++) begin
      line1_v[i] = rand_line();
      line2_v[i] = rand_line();
    end
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;
    mdl_ptr = NR - 1;
    @(negedge clk);

    line1_v[2] = {"HELLO", {(LL - 5){8'h20}}};
    line2_v[2] = {"WORLD", {(LL - 5){8'h20}}};
    bus_if.req = 4'b0100;
    do_transfer(50, 1'b0, 1'b0);

    for (int n = 0; n < 5; n++) begin
      bus_if.req = 4'b1111;
      do_transfer(int'($urandom_range(0, 20)), 1'b0, 1'b0);
    end

    bus_if.req = 4'b1010;
    do_transfer(10, 1'b0, 1'b1);
    bus_if.req = 4'b1010;
    do_transfer(20, 1'b1, 1'b0);

    bus_if.req = 4'b0011;
    do_transfer(-1, 1'b0, 1'b0);
    bus_if.req = 4'b0011;
    do_transfer(5, 1'b0, 1'b0);

    bus_if.req = 4'b1111;
    do_transfer(TO, 1'b0, 1'b0);

    for (int n = 0; n < 24; n++) begin
      bus_if.req = NR'($urandom_range(1, 15));
      case ($urandom_range(0, 5))
        0:       lat = -1;
        1:       lat = int'($urandom_range(90, 110));
        default: lat = int'($urandom_range(0, 60));
      endcase
      keep = ($urandom_range(0, 3) == 0);
      do_transfer(lat, prev_keep, keep);
    end
    bus_if.lcd_done = 1'b0;
    prev_keep = 1'b0;
    @(negedge clk);

    bus_if.req = 4'b1000;
    @(negedge clk);
    chk("mid_grant", 128'(bus_if.grant), 128'(4'b1000));
    @(negedge clk);
    chk("mid_send", 128'(bus_if.lcd_send), 128'(1));
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    check_reset_outputs("midrst_hold");
    rst = 1'b0;
    mdl_ptr = NR - 1;
    bus_if.req = 4'b0010;
    do_transfer(30, 1'b0, 1'b0);
    bus_if.req = 4'b1111;
    do_transfer(15, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
